// File: rtl/pwr_event_monitor.sv
// Power event monitor: edge-captured alert/power-fail events, Avalon-MM CSRs, IRQ and holdoff shutdown FSM.
// Optional feature macro: PWR_EVT_COUNTERS_EN (saturating 16-bit rise counters in register 3).
`timescale 1ns/1ps

module pwr_event_monitor #(
    parameter int unsigned HOLDOFF_CYCLES = 12500
) (
    input  logic        clk125,
    input  logic        sys_rst_n,
    input  logic        voltage_alert_d,
    input  logic        power_failure_d,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        shutdown_req
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned EVT_W     = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        TRIPPED = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   holdoff_cnt;
    logic [CNT_W-1:0]   holdoff_cnt_next;
    logic               shutdown_next;

    logic               va_prev;
    logic               pf_prev;
    logic               primed;
    logic [EVT_W-1:0]   event_q;
    logic [EVT_W-1:0]   mask_q;

    logic               va_rise_c;
    logic               va_fall_c;
    logic               pf_rise_c;
    logic               pf_fall_c;
    logic [EVT_W-1:0]   evt_set_c;
    logic [EVT_W-1:0]   evt_clr_c;
    logic               wr_event_c;
    logic               wr_mask_c;
    logic               wr_count_c;
    logic [31:0]        count_word_c;
    logic [31:0]        rd_mux_c;
    logic               unused_c;

    // Edges only count once the history has been loaded after reset release.
    assign va_rise_c = primed &  voltage_alert_d & ~va_prev;
    assign va_fall_c = primed & ~voltage_alert_d &  va_prev;
    assign pf_rise_c = primed &  power_failure_d & ~pf_prev;
    assign pf_fall_c = primed & ~power_failure_d &  pf_prev;
    assign evt_set_c = {pf_fall_c, pf_rise_c, va_fall_c, va_rise_c};

    assign wr_event_c = avs_write && (avs_address == 2'd1);
    assign wr_mask_c  = avs_write && (avs_address == 2'd2);
    assign wr_count_c = avs_write && (avs_address == 2'd3);
    assign evt_clr_c  = wr_event_c ? avs_writedata[EVT_W-1:0] : EVT_W'(0);
    assign unused_c   = ^{avs_writedata[31:EVT_W], wr_count_c};

    // Edge history, sticky events (set beats W1C), mask and interrupt.
    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            va_prev <= 1'b0;
            pf_prev <= 1'b0;
            primed  <= 1'b0;
            event_q <= '0;
            mask_q  <= '0;
            irq     <= 1'b0;
        end else begin
            va_prev <= voltage_alert_d;
            pf_prev <= power_failure_d;
            primed  <= 1'b1;
            event_q <= (event_q & ~evt_clr_c) | evt_set_c;
            if (wr_mask_c) begin
                mask_q <= avs_writedata[EVT_W-1:0];
            end
            irq     <= |(event_q & mask_q);
        end
    end

`ifdef PWR_EVT_COUNTERS_EN
    logic [CNT_W-1:0] va_cnt;
    logic [CNT_W-1:0] pf_cnt;

    // Saturating rise counters; a register-3 write clears both and drops a coincident increment.
    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            va_cnt <= '0;
            pf_cnt <= '0;
        end else if (wr_count_c) begin
            va_cnt <= '0;
            pf_cnt <= '0;
        end else begin
            if (va_rise_c && (va_cnt != CNT_MAX)) begin
                va_cnt <= va_cnt + CNT_W'(1);
            end
            if (pf_rise_c && (pf_cnt != CNT_MAX)) begin
                pf_cnt <= pf_cnt + CNT_W'(1);
            end
        end
    end

    assign count_word_c = {pf_cnt, va_cnt};
`else
    assign count_word_c = 32'h0000_0000;
`endif

    // Register read mux.
    always_comb begin
        rd_mux_c = 32'h0000_0000;
        case (avs_address)
            2'd0:    rd_mux_c = {29'h0, shutdown_req, power_failure_d, voltage_alert_d};
            2'd1:    rd_mux_c = {28'h0, event_q};
            2'd2:    rd_mux_c = {28'h0, mask_q};
            default: rd_mux_c = count_word_c;
        endcase
    end

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux_c;
        end
    end

    // Shutdown FSM state register.
    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            holdoff_cnt  <= '0;
            shutdown_req <= 1'b0;
        end else begin
            state        <= state_next;
            holdoff_cnt  <= holdoff_cnt_next;
            shutdown_req <= shutdown_next;
        end
    end

    // Shutdown FSM next state; shutdown_req is registered from the next state.
    always_comb begin
        state_next       = state;
        holdoff_cnt_next = holdoff_cnt;
        shutdown_next    = 1'b0;
        case (state)
            IDLE: begin
                if (power_failure_d) begin
                    state_next       = ARMING;
                    holdoff_cnt_next = '0;
                end
            end
            ARMING: begin
                if (!power_failure_d) begin
                    state_next = IDLE;
                end else if (holdoff_cnt == HOLD_LAST) begin
                    state_next = TRIPPED;
                end else if (holdoff_cnt != CNT_MAX) begin
                    holdoff_cnt_next = holdoff_cnt + CNT_W'(1);
                end
            end
            TRIPPED: begin
                if (!power_failure_d) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        shutdown_next = (state_next == TRIPPED);
    end

endmodule

// File: doc/pwr_event_monitor.md
PWR_EVENT_MONITOR -- requirements
Module: pwr_event_monitor

Interface
REQ-001 The block SHALL have parameter HOLDOFF_CYCLES, default 12500, meaning clk125 cycles power_failure_d must stay high before shutdown_req asserts (100 us); legal range 1..65535.
REQ-002 The block SHALL have port clk125  input  1  the 125 MHz system clock; all logic runs on its rising edge.
REQ-003 The block SHALL have port sys_rst_n  input  1  the reset: asynchronous, active-low.
REQ-004 The block SHALL have port voltage_alert_d  input  1  the debounced voltage alert level, already synchronous to clk125.
REQ-005 The block SHALL have port power_failure_d  input  1  the debounced power-fail level, active-high, already synchronous to clk125.
REQ-006 The block SHALL have port avs_address  input  2  the 32-bit word register index.
REQ-007 The block SHALL have ports avs_read  input  1 and avs_write  input  1, the Avalon-MM strobes; there is no waitrequest.
REQ-008 The block SHALL have port avs_writedata  input  32  the write data.
REQ-009 The block SHALL have port avs_readdata  output  32  the read data.
REQ-010 The block SHALL have port irq  output  1  the level interrupt to the PCIe bridge.
REQ-011 The block SHALL have port shutdown_req  output  1  the power-fail shutdown request to platform logic.

Function
REQ-012 The block SHALL implement register 0 STATUS (RO): bit0 = voltage_alert_d, bit1 = power_failure_d, bit2 = shutdown_req, other bits 0.
REQ-013 The block SHALL implement register 1 EVENT (RW1C) with sticky flags: bit0 VA rise, bit1 VA fall, bit2 PF rise, bit3 PF fall, other bits 0.
REQ-014 The block SHALL implement register 2 IRQ_MASK (RW) in bits[3:0]; other bits SHALL read 0.
REQ-015 The block SHALL implement register 3 COUNT with [15:0] = VA rise count and [31:16] = PF rise count.
REQ-016 Edges SHALL be detected against the previous-cycle sampled level, and the EVENT bit SHALL set on the cycle after the input transition.
REQ-017 The first clk125 cycle after reset release SHALL only capture the input levels and SHALL NOT generate events, so a level already high at reset produces no rise event.
REQ-018 If an event set and a W1C clear of the same bit occur in the same cycle, the set SHALL win.
REQ-019 avs_readdata SHALL be valid exactly one cycle after avs_read, and SHALL hold its last value otherwise.
REQ-020 A write to register 0 SHALL have no effect.
REQ-021 irq SHALL be registered: irq = OR(EVENT[3:0] AND IRQ_MASK[3:0]), one cycle after the contributing state changes.
REQ-022 The shutdown FSM SHALL have three states: IDLE, ARMING and TRIPPED.
REQ-023 In IDLE, power_failure_d=1 SHALL load holdoff_cnt=0 and move the FSM to ARMING.
REQ-024 In ARMING, holdoff_cnt SHALL increment each cycle while power_failure_d=1.
REQ-025 In ARMING, when holdoff_cnt reaches HOLDOFF_CYCLES-1 the FSM SHALL move to TRIPPED.
REQ-026 In ARMING, power_failure_d=0 SHALL return the FSM to IDLE without asserting shutdown_req.
REQ-027 In TRIPPED, shutdown_req SHALL be 1.
REQ-028 In TRIPPED, power_failure_d=0 SHALL return the FSM to IDLE, and shutdown_req SHALL drop the next cycle.
REQ-029 shutdown_req SHALL be registered and SHALL first assert exactly HOLDOFF_CYCLES+1 cycles after the power_failure_d rise.
REQ-030 holdoff_cnt SHALL be 16 bits and SHALL never wrap.

Reset
REQ-031 On sys_rst_n=0 the block SHALL asynchronously clear: EVENT, IRQ_MASK, both counters, holdoff_cnt, the edge-detect history and avs_readdata (all to 0).
REQ-032 On sys_rst_n=0, irq and shutdown_req SHALL be 0 and the FSM SHALL be in IDLE.
REQ-033 If reset is asserted mid-ARMING or in TRIPPED, shutdown_req SHALL deassert immediately, and holdoff timing SHALL restart from IDLE after release.

Configuration
REQ-034 With macro PWR_EVT_COUNTERS_EN defined, the counters SHALL be 16-bit, increment on each rise event, and saturate at 0xFFFF.
REQ-035 With PWR_EVT_COUNTERS_EN defined, any write to register 3 SHALL clear both counters; an increment in the same cycle as the write SHALL be lost, and the count SHALL be 0.
REQ-036 Without PWR_EVT_COUNTERS_EN, no counter flops SHALL exist, register 3 SHALL read 0x00000000 and writes to it SHALL be ignored.

Verification
REQ-037 The bench SHALL cover: voltage_alert_d 0->1 with IRQ_MASK=0x1 -> EVENT=0x1 and irq=1 on the 2nd cycle; write EVENT=0x1 -> irq=0 one cycle after the write.
REQ-038 The bench SHALL cover: power_failure_d held high with HOLDOFF_CYCLES=8 -> shutdown_req=1 at cycle 9; power_failure_d low -> shutdown_req=0 one cycle later.
REQ-039 The bench SHALL cover: a power_failure_d pulse of 5 cycles with HOLDOFF_CYCLES=8 -> shutdown_req stays 0, EVENT=0xC, and COUNT[31:16]=1 (macro on).
REQ-040 The bench SHALL cover: voltage_alert_d high through reset release -> EVENT stays 0x0 and STATUS=0x1.
REQ-041 The bench SHALL cover: a W1C of bit0 in the same cycle as a new VA rise -> EVENT bit0 remains 1.
REQ-042 The bench SHALL cover: 65537 VA rises with the macro on -> COUNT[15:0]=0xFFFF; with the macro off -> COUNT reads 0x00000000.
